free_list_ctrl: RTL and testbench

- Controller for a free list of entry indices 0..p_num_entries-1, used by the op-centric queues to hand out and reclaim slot indices.
- Drives an external 1-read/1-write index memory (v3a_Mem1r1w). That memory resets to mem[i]=i, so the list starts full.
- Alloc is a val/rdy producer; free is a val/rdy consumer.
- Tracks outstanding indices, so a double free or a free of a never-allocated index is dropped and flagged.

---
 rtl/free_list_pkg.sv | 16 +
 rtl/free_list_ptr.sv | 25 ++
 rtl/free_list_ctrl.sv | 132 +++++++++++++
 tb/tb_free_list_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/free_list_pkg.sv
// Shared types and helpers for the free-list controller: default sizing,
// the index type and the pointer wrap rule.
package free_list_pkg;

  localparam int unsigned default_num_entries = 8;
  localparam int unsigned default_addr_width  = $clog2(default_num_entries);
  localparam int unsigned default_cnt_width   = $clog2(default_num_entries + 1);

  typedef logic [default_addr_width-1:0] idx_t;

  // Advance a ring pointer over 0..n-1; n need not be a power of two.
  function automatic logic [31:0] next_ptr(input logic [31:0] ptr, input logic [31:0] n);
    return (ptr == n - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/free_list_ptr.sv
// Wrap-around ring pointer with an increment enable; used for the head
// (allocation side) and tail (free side) of the index ring.
module free_list_ptr
  import free_list_pkg::*;
#(
  parameter int unsigned p_num_entries = default_num_entries,
  parameter int unsigned p_addr_width  = $clog2(p_num_entries)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    inc,
  output logic [p_addr_width-1:0] ptr
);

  // NOTE: registers are written with non-blocking assignments so every
  // flop samples the pre-edge values of the others, as the hardware does.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= p_addr_width'(next_ptr(32'(ptr), p_num_entries));
    end
  end

endmodule

// File: rtl/free_list_ctrl.sv
// Free-list controller: hands out indices from an external 1r1w ring memory
// and reclaims them, rejecting frees of indices that are not outstanding.
module free_list_ctrl
  import free_list_pkg::*;
#(
  parameter int unsigned p_num_entries = default_num_entries,
  parameter int unsigned p_addr_width  = $clog2(p_num_entries),
  parameter int unsigned p_cnt_width   = $clog2(p_num_entries + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    alloc_val,
  input  logic                    alloc_rdy,
  output logic [p_addr_width-1:0] alloc_idx,
  input  logic                    free_val,
  output logic                    free_rdy,
  input  logic [p_addr_width-1:0] free_idx,
  output logic                    mem_write_en,
  output logic [p_addr_width-1:0] mem_write_addr,
  output logic [p_addr_width-1:0] mem_write_data,
  output logic                    mem_read_en,
  output logic [p_addr_width-1:0] mem_read_addr,
  input  logic [p_addr_width-1:0] mem_read_data,
  output logic [p_cnt_width-1:0]  free_count,
  output logic                    err_bad_free,
  output logic [p_addr_width-1:0] err_idx
);

  // Outstanding bitmap spans the full index space so out-of-range indices
  // (non-power-of-two sizes) read as "not outstanding".
  localparam int unsigned          p_vec_size = 1 << p_addr_width;
  localparam logic [p_cnt_width-1:0] p_full   = p_cnt_width'(p_num_entries);
  localparam logic [p_cnt_width-1:0] p_one    = p_cnt_width'(1);

  logic [p_cnt_width-1:0]  count;
  logic [p_vec_size-1:0]   alloc_vec;
  logic [p_vec_size-1:0]   alloc_vec_next;
  logic [p_addr_width-1:0] head;
  logic [p_addr_width-1:0] tail;
  logic                    alloc_fire;
  logic                    alloc_in_range;
  logic                    free_fire;
  logic                    free_in_range;
  logic                    free_legal;
  logic                    free_bad;

  assign mem_read_en   = (count != '0) & ~reset;
  assign mem_read_addr = head;
  assign alloc_val     = mem_read_en;
  assign alloc_idx     = mem_read_data;
  assign alloc_fire    = alloc_val & alloc_rdy;
  assign free_rdy      = ~reset;
  assign free_count    = count;

  assign alloc_in_range = 32'(alloc_idx) < p_num_entries;
  assign free_in_range  = 32'(free_idx) < p_num_entries;
  assign free_fire      = free_val & ~reset;
  // Legality uses the registered bitmap, so a same-cycle alloc+free of one
  // index is rejected while the alloc still completes.
  assign free_legal     = free_fire & free_in_range & alloc_vec[free_idx];
  assign free_bad       = free_fire & ~free_legal;

  assign mem_write_en   = free_legal;
  assign mem_write_addr = tail;
  assign mem_write_data = free_idx;

  free_list_ptr #(
    .p_num_entries (p_num_entries),
    .p_addr_width  (p_addr_width)
  ) u_head (
    .clk   (clk),
    .reset (reset),
    .inc   (alloc_fire),
    .ptr   (head)
  );

  free_list_ptr #(
    .p_num_entries (p_num_entries),
    .p_addr_width  (p_addr_width)
  ) u_tail (
    .clk   (clk),
    .reset (reset),
    .inc   (free_legal),
    .ptr   (tail)
  );

  // NOTE: the next-state vector is assigned its current value first, so
  // every path through this block drives it and no latch is inferred.
  always_comb begin
    alloc_vec_next = alloc_vec;
    if (alloc_fire && alloc_in_range) begin
      alloc_vec_next[alloc_idx] = 1'b1;
    end
    if (free_legal) begin
      alloc_vec_next[free_idx] = 1'b0;
    end
  end

  // NOTE: the outstanding bitmap is plain flops and is cleared on reset;
  // the index ring memory outside this block restores its own identity
  // contents in the same reset cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      alloc_vec <= '0;
    end else begin
      alloc_vec <= alloc_vec_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= p_full;
    end else if (free_legal && !alloc_fire) begin
      count <= count + p_one;
    end else if (!free_legal && alloc_fire) begin
      count <= count - p_one;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_bad_free <= 1'b0;
      err_idx      <= '0;
    end else begin
      err_bad_free <= free_bad;
      if (free_bad) begin
        err_idx <= free_idx;
      end
    end
  end

endmodule

// File: tb/tb_free_list_ctrl.sv
// Self-checking bench for free_list_ctrl: table vectors, directed corner
// sequences and random traffic against a FIFO-of-free-indices model.
module tb_free_list_ctrl;
  import free_list_pkg::*;

  localparam int unsigned n = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       alloc_val;
  logic       alloc_rdy = 1'b0;
  idx_t       alloc_idx;
  logic       free_val = 1'b0;
  logic       free_rdy;
  idx_t       free_idx = '0;
  logic       mem_write_en;
  idx_t       mem_write_addr;
  idx_t       mem_write_data;
  logic       mem_read_en;
  idx_t       mem_read_addr;
  idx_t       mem_read_data;
  logic [3:0] free_count;
  logic       err_bad_free;
  idx_t       err_idx;

  always #5 clk = ~clk;

  free_list_ctrl #(.p_num_entries(n)) dut (
    .clk            (clk),
    .reset          (reset),
    .alloc_val      (alloc_val),
    .alloc_rdy      (alloc_rdy),
    .alloc_idx      (alloc_idx),
    .free_val       (free_val),
    .free_rdy       (free_rdy),
    .free_idx       (free_idx),
    .mem_write_en   (mem_write_en),
    .mem_write_addr (mem_write_addr),
    .mem_write_data (mem_write_data),
    .mem_read_en    (mem_read_en),
    .mem_read_addr  (mem_read_addr),
    .mem_read_data  (mem_read_data),
    .free_count     (free_count),
    .err_bad_free   (err_bad_free),
    .err_idx        (err_idx)
  );

  // Stand-in for the 1r1w index memory: identity on reset, async read.
  idx_t mem [n];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(n); i++) mem[i] <= idx_t'(i);
    end else if (mem_write_en) begin
      mem[mem_write_addr] <= mem_write_data;
    end
  end
  assign mem_read_data = mem[mem_read_addr];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
  endtask

  // Reference model: free indices in hand-out order plus an outstanding set.
  int unsigned fq[$];
  bit          outst [n];
  bit          m_err;
  int unsigned m_err_idx;
  logic        cur_a;
  logic        cur_f;
  idx_t        cur_i;

  function automatic bit exp_legal();
    return cur_f && (int'(cur_i) < int'(n)) && outst[cur_i];
  endfunction

  task automatic model_reset();
    fq.delete();
    for (int i = 0; i < int'(n); i++) begin
      fq.push_back(i);
      outst[i] = 1'b0;
    end
    m_err = 1'b0;
    m_err_idx = 0;
  endtask

  task automatic model_check();
    bit legal;
    legal = exp_legal();
    check("alloc_val", alloc_val, fq.size() != 0);
    check("mem_read_en", mem_read_en, fq.size() != 0);
    if (fq.size() != 0) check("alloc_idx", alloc_idx, fq[0]);
    check("free_count", free_count, fq.size());
    check("err_bad_free", err_bad_free, m_err);
    if (m_err) check("err_idx", err_idx, m_err_idx);
    check("mem_write_en", mem_write_en, legal);
    if (legal) check("mem_write_data", mem_write_data, cur_i);
  endtask

  task automatic model_step();
    bit legal;
    bit fire;
    int unsigned x;
    legal = exp_legal();
    fire  = cur_a && (fq.size() != 0);
    m_err = cur_f && !legal;
    if (m_err) m_err_idx = cur_i;
    if (fire) begin
      x = fq.pop_front();
      outst[x] = 1'b1;
    end
    if (legal) begin
      fq.push_back(cur_i);
      outst[cur_i] = 1'b0;
    end
  endtask

  task automatic apply(input logic a, input logic f, input idx_t i);
    @(negedge clk);
    alloc_rdy = a;
    free_val  = f;
    free_idx  = i;
    cur_a = a;
    cur_f = f;
    cur_i = i;
    #1;
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
  endtask

  task automatic step(input logic a, input logic f, input idx_t i);
    apply(a, f, i);
    model_check();
    advance();
  endtask

  task automatic do_reset(input logic a, input logic f);
    @(negedge clk);
    reset     = 1'b1;
    alloc_rdy = a;
    free_val  = f;
    free_idx  = idx_t'(3);
    #1;
    check("alloc_val_in_reset", alloc_val, 0);
    check("free_rdy_in_reset", free_rdy, 0);
    check("mem_write_en_in_reset", mem_write_en, 0);
    @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    alloc_rdy = 1'b0;
    free_val  = 1'b0;
    model_reset();
    #1;
    check("free_rdy_after_reset", free_rdy, 1);
    check("free_count_after_reset", free_count, n);
    check("err_after_reset", err_bad_free, 0);
    @(posedge clk);
  endtask

  typedef struct {
    logic       a_rdy;
    logic       f_val;
    idx_t       f_idx;
    logic       e_val;
    idx_t       e_idx;
    int         e_cnt;
    logic       e_err;
    idx_t       e_eidx;
  } vec_t;

  function automatic vec_t mk(input logic a, input logic f, input int i, input logic ev,
                              input int ei, input int ec, input logic ee, input int eei);
    vec_t v;
    v.a_rdy = a;  v.f_val = f;  v.f_idx = idx_t'(i);
    v.e_val = ev; v.e_idx = idx_t'(ei); v.e_cnt = ec;
    v.e_err = ee; v.e_eidx = idx_t'(eei);
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs[$];
    int unsigned x;
    int unsigned pool[$];
    logic a, f;
    idx_t idx;
    int   exp_seq[4];

    // Drain 8, offer stops, refill 5 then 2, drain, then double-free 3.
    for (int i = 0; i < 8; i++) vecs.push_back(mk(1, 0, 0, 1, i, 8 - i, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 5, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 2, 1, 5, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 5, 2, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 2, 1, 0, 0));
    vecs.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3, 1, 3, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 3, 1, 1, 3));

    do_reset(1'b0, 1'b0);
    foreach (vecs[k]) begin
      apply(vecs[k].a_rdy, vecs[k].f_val, vecs[k].f_idx);
      check($sformatf("tbl%0d_alloc_val", k), alloc_val, vecs[k].e_val);
      if (vecs[k].e_val) check($sformatf("tbl%0d_alloc_idx", k), alloc_idx, vecs[k].e_idx);
      check($sformatf("tbl%0d_free_count", k), free_count, vecs[k].e_cnt);
      check($sformatf("tbl%0d_err", k), err_bad_free, vecs[k].e_err);
      if (vecs[k].e_err) check($sformatf("tbl%0d_err_idx", k), err_idx, vecs[k].e_eidx);
      advance();
    end

    // Simultaneous legal free of 1 and alloc of 4.
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);
    apply(1'b1, 1'b1, idx_t'(1));
    check("sim_alloc_idx", alloc_idx, 4);
    check("sim_count_before", free_count, 4);
    check("sim_wr_en", mem_write_en, 1);
    check("sim_wr_addr", mem_write_addr, 0);
    check("sim_wr_data", mem_write_data, 1);
    model_check();
    advance();
    apply(1'b0, 1'b0, '0);
    check("sim_count_after", free_count, 4);
    model_check();
    advance();
    exp_seq = '{5, 6, 7, 1};
    for (int k = 0; k < 4; k++) begin
      apply(1'b1, 1'b0, '0);
      check($sformatf("sim_next%0d", k), alloc_idx, exp_seq[k]);
      model_check();
      advance();
    end

    // Free of a never-allocated index right after reset.
    do_reset(1'b0, 1'b0);
    apply(1'b0, 1'b1, idx_t'(6));
    check("bad6_wr_en", mem_write_en, 0);
    model_check();
    advance();
    apply(1'b0, 1'b0, '0);
    check("bad6_err", err_bad_free, 1);
    check("bad6_err_idx", err_idx, 6);
    check("bad6_count", free_count, 8);
    model_check();
    advance();
    apply(1'b0, 1'b0, '0);
    check("bad6_err_pulse", err_bad_free, 0);
    advance();

    // Double free: count returns to full, not beyond.
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, idx_t'(i));
    apply(1'b0, 1'b1, idx_t'(3));
    check("dbl_wr_en", mem_write_en, 0);
    model_check();
    advance();
    apply(1'b0, 1'b0, '0);
    check("dbl_err", err_bad_free, 1);
    check("dbl_err_idx", err_idx, 3);
    check("dbl_count", free_count, 8);
    model_check();
    advance();

    // 20 alloc/free pairs wrap both pointers; then reset mid-stream.
    do_reset(1'b0, 1'b0);
    for (int p = 0; p < 20; p++) begin
      x = fq[0];
      apply(1'b1, 1'b0, '0);
      check("wrap_idx_range", alloc_idx < idx_t'(n - 1) || alloc_idx == idx_t'(n - 1), 1);
      model_check();
      advance();
      step(1'b0, 1'b1, idx_t'(x));
    end
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    do_reset(1'b1, 1'b1);
    apply(1'b0, 1'b0, '0);
    check("midrst_count", free_count, 8);
    check("midrst_alloc_idx", alloc_idx, 0);
    model_check();
    advance();

    // Random traffic, frees biased toward outstanding indices.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(99) == 0) do_reset(1'($urandom_range(1)), 1'($urandom_range(1)));
      a = 1'($urandom_range(1));
      f = 1'($urandom_range(1));
      pool.delete();
      for (int i = 0; i < int'(n); i++) if (outst[i]) pool.push_back(i);
      if (pool.size() != 0 && $urandom_range(3) != 0)
        idx = idx_t'(pool[$urandom_range(pool.size() - 1)]);
      else
        idx = idx_t'($urandom_range(n - 1));
      step(a, f, idx);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
